uart_rx: RTL and testbench

UART receiver, the serial-in counterpart of the team's uart_tx. It recovers 8N1-style frames from the asynchronous rx line using the shared 16x oversampling tick (s_tick), and presents each byte with a one-cycle done pulse. It flags a framing error when the stop bit is sampled low. It sits between the pad and the RX FIFO/controller, driven by the same baud generator as uart_tx.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to uart_tx and uart_rx,
// default frame parameters and the oversampling tick positions.
package uart_pkg;

  // State encoding is shared with uart_tx so state_out decodes identically.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

  // Tick positions within a 16x oversampled bit period.
  localparam int MID_BIT  = 7;
  localparam int FULL_BIT = 15;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised reset value so it can match the idle level of the line.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability a full clock to settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers LSB-first frames from rx using the shared 16x
// oversampling tick, pulses rx_done_tick per frame and flags a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic [1:0]      state_out
);

  // The s counter is 4 bits for a 16-tick bit, widened only when a long
  // stop bit (e.g. SB_TICK=32) needs to count further than 15.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(MID_BIT);
  localparam logic [SW-1:0] S_FULL = SW'(FULL_BIT);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  uart_state_e     state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic            rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // State, counters, shift register and registered frame outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: start detection runs every clk, all bit timing on s_tick.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    dout_next  = dout_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          s_next     = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == S_MID) begin
            if (!rx_s) begin
              s_next     = '0;
              n_next     = '0;
              state_next = ST_DATA;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == S_FULL) begin
            s_next = '0;
            b_next = (b_reg >> 1) | (DBIT'(rx_s) << (DBIT - 1));
            if (n_reg == N_LAST) begin
              state_next = ST_STOP;
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP) begin
            state_next = ST_IDLE;
            dout_next  = b_reg;
            done_next  = 1'b1;
            err_next   = ~rx_s;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_dout      = dout_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = err_reg;
  assign state_out    = state_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clk

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         gap_bits;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       line;
  logic       sel2;
  logic       rx1, rx2;
  logic [7:0] dout1;
  logic [6:0] dout2;
  logic       done1, done2, err1, err2;
  logic [1:0] state1, state2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_done_cyc1 = 0;
  int   last_done_cyc2 = 0;
  int   done_count1 = 0;
  int   done_count2 = 0;
  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;
  exp_t exp_q1[$];
  exp_t exp_q2[$];
  vec_t tbl[5];

  assign rx1 = sel2 ? 1'b1 : line;
  assign rx2 = sel2 ? line : 1'b1;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx1),
    .s_tick       (s_tick),
    .rx_dout      (dout1),
    .rx_done_tick (done1),
    .frame_err    (err1),
    .state_out    (state1)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx2),
    .s_tick       (s_tick),
    .rx_dout      (dout2),
    .rx_done_tick (done2),
    .frame_err    (err2),
    .state_out    (state2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk-wide oversampling tick every 4 clk.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame onto the line. A low stop bit is released after 3/4 of
  // the bit so the receiver's immediate restart is rejected as a glitch.
  task automatic sendFrame(input logic [7:0] data, input int dbit,
                           input logic stop_bit, input int stop_clks);
    line = 1'b0;
    start_cyc = cyc;
    waitClks(BIT_CLKS);
    for (int i = 0; i < dbit; i++) begin
      line = data[i];
      waitClks(BIT_CLKS);
    end
    if (stop_bit) begin
      line = 1'b1;
      waitClks(stop_clks);
    end else begin
      line = 1'b0;
      waitClks(48);
      line = 1'b1;
      waitClks(stop_clks - 48);
    end
  endtask

  // Frame-level reference: a receiver delivers the low dbit bits of what
  // was sent and reports an error exactly when the stop bit was low.
  function automatic exp_t modelFrame(input logic [7:0] data, input int dbit,
                                      input logic stop_bit);
    exp_t e;
    e.data = data & 8'((1 << dbit) - 1);
    e.err  = ~stop_bit;
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int gap_bits,
                               input logic [7:0] exp_data, input logic exp_err);
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    exp_q1.push_back(e);
    sendFrame(data, 8, stop_bit, BIT_CLKS);
    waitClks(gap_bits * BIT_CLKS);
  endtask

  // Scoreboard: every done pulse must match the oldest pending frame.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      checkOutput("dut1 pending frame on done", 32'(exp_q1.size() > 0), 1);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        checkOutput("dut1 rx_dout", dout1, e.data);
        checkOutput("dut1 frame_err", err1, e.err);
      end
      checkOutput("dut1 done width", prev_done1, 0);
      last_done_cyc1 = cyc;
      done_count1++;
    end else if (err1) begin
      checkOutput("dut1 frame_err without done", done1, 1);
    end
    if (done2) begin
      checkOutput("dut2 pending frame on done", 32'(exp_q2.size() > 0), 1);
      if (exp_q2.size() > 0) begin
        e = exp_q2.pop_front();
        checkOutput("dut2 rx_dout", dout2, e.data);
        checkOutput("dut2 frame_err", err2, e.err);
      end
      checkOutput("dut2 done width", prev_done2, 0);
      last_done_cyc2 = cyc;
      done_count2++;
    end
    prev_done1 = done1;
    prev_done2 = done2;
  end

  initial begin
    int   saved_done;
    exp_t e;
    logic [7:0] d;
    logic sb;
    int   gap;

    tbl[0] = '{8'h00, 1'b1, 0, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 0, 8'hFF, 1'b0};
    tbl[2] = '{8'h55, 1'b1, 2, 8'h55, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 2, 8'h3C, 1'b1};
    tbl[4] = '{8'h81, 1'b1, 2, 8'h81, 1'b0};

    line    = 1'b1;
    sel2    = 1'b0;
    reset_n = 1'b0;
    waitClks(5);
    checkOutput("reset rx_dout", dout1, 0);
    checkOutput("reset rx_done_tick", done1, 0);
    checkOutput("reset frame_err", err1, 0);
    checkOutput("reset state_out", state1, 0);
    reset_n = 1'b1;
    waitClks(2 * BIT_CLKS);

    // Single frame with latency: 8+8*16+16 = 152 ticks after the start
    // edge, plus sync and tick phase (608..611 clk).
    applyStimulus(8'hA5, 1'b1, 2, 8'hA5, 1'b0);
    checkOutput("A5 done count", done_count1, 1);
    checkRange("A5 latency", last_done_cyc1 - start_cyc, 4 * 152 - 1, 4 * 152 + 4);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].data, tbl[i].stop_bit, tbl[i].gap_bits, tbl[i].exp_data, tbl[i].exp_err);
    end
    checkOutput("table done count", done_count1, 6);

    // Short low glitch in idle: start is entered, then abandoned at mid-bit.
    saved_done = done_count1;
    line = 1'b0;
    waitClks(8);
    checkOutput("glitch enters start", state1, 1);
    waitClks(4);
    line = 1'b1;
    waitClks(BIT_CLKS);
    checkOutput("glitch back to idle", state1, 0);
    checkOutput("glitch no done", done_count1, saved_done);
    checkOutput("glitch rx_dout held", dout1, tbl[4].exp_data);

    // Randomized frames; a bad stop is always followed by at least one idle bit.
    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 3) != 0);
      gap = sb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      e   = modelFrame(d, 8, sb);
      applyStimulus(d, sb, gap, e.data, e.err);
    end

    // Reset in the middle of 0xF0 after four data bits.
    line = 1'b0;
    waitClks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      line = 1'b0;
      waitClks(BIT_CLKS);
    end
    checkOutput("mid-frame state data", state1, 2);
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset rx_dout", dout1, 0);
    checkOutput("mid reset rx_done_tick", done1, 0);
    checkOutput("mid reset frame_err", err1, 0);
    checkOutput("mid reset state_out", state1, 0);
    line = 1'b1;
    waitClks(3);
    reset_n = 1'b1;
    waitClks(2 * BIT_CLKS);
    saved_done = done_count1;
    applyStimulus(8'h12, 1'b1, 2, 8'h12, 1'b0);
    checkOutput("post reset done count", done_count1, saved_done + 1);

    // DBIT=7, SB_TICK=32: 8+7*16+32 = 152 ticks, one bit later than the
    // same 7-bit frame would finish with a single stop bit.
    sel2 = 1'b1;
    waitClks(BIT_CLKS);
    e = modelFrame(8'h5A, 7, 1'b1);
    exp_q2.push_back(e);
    sendFrame(8'h5A, 7, 1'b1, 2 * BIT_CLKS);
    waitClks(BIT_CLKS);
    checkOutput("dut2 done count", done_count2, 1);
    checkRange("dut2 latency", last_done_cyc2 - start_cyc, 4 * 152 - 1, 4 * 152 + 4);
    checkRange("dut2 latency vs 1-stop", last_done_cyc2 - start_cyc,
               4 * (8 + 7 * 16 + 16) + 64 - 1, 4 * (8 + 7 * 16 + 16) + 64 + 4);
    sel2 = 1'b0;

    waitClks(200);
    checkOutput("dut1 frames outstanding", exp_q1.size(), 0);
    checkOutput("dut2 frames outstanding", exp_q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
